// File: rtl/adc_serial_if.sv
// Serial ECG ADC front end: pulses CONVST, waits for BUSY to fall, then clocks
// DATA_WIDTH bits out of the ADC MSB first and presents them with a valid pulse.
module adc_serial_if #(
  parameter int DATA_WIDTH   = 11,
  parameter int SCLK_DIV     = 4,
  parameter int CONVST_LEN   = 2,
  parameter int CONV_TIMEOUT = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_convst,
  output logic                  o_busy,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_rd_valid,
  output logic                  o_timeout,
  output logic                  o_overrun,
  output logic                  o_adc_convst_n,
  input  logic                  i_adc_busy,
  output logic                  o_adc_cs_n,
  output logic                  o_adc_sclk,
  input  logic                  i_adc_sdo
);

  typedef enum logic [2:0] {
    S_IDLE, S_CONVST, S_CONV_WAIT, S_READ, S_DONE
  } state_t;

  localparam int CNT_W = $clog2(CONV_TIMEOUT + CONVST_LEN + 1);
  localparam int DIV_W = $clog2(SCLK_DIV);
  localparam int BIT_W = $clog2(DATA_WIDTH + 1);

  localparam logic [CNT_W-1:0] CONVST_LAST  = CNT_W'(CONVST_LEN - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(CONV_TIMEOUT - 1);
  localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(SCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST     = BIT_W'(DATA_WIDTH - 1);

  state_t                state_q, state_d;
  logic                  convst_q, convst_d;
  logic [1:0]            busy_sync_q, busy_sync_d;
  logic                  busy_prev_q, busy_prev_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  busy_q, busy_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  timeout_q, timeout_d;
  logic                  overrun_q, overrun_d;
  logic                  convst_n_q, convst_n_d;
  logic                  cs_n_q, cs_n_d;
  logic                  sclk_q, sclk_d;

  logic req_edge;
  logic busy_fall;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    req_edge    = i_convst & ~convst_q;
    busy_fall   = busy_prev_q & ~busy_sync_q[1];

    state_d     = state_q;
    convst_d    = i_convst;
    busy_sync_d = {busy_sync_q[0], i_adc_busy};
    busy_prev_d = busy_sync_q[1];
    cnt_d       = cnt_q;
    div_d       = div_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    data_d      = data_q;
    busy_d      = busy_q;
    rd_valid_d  = 1'b0;
    timeout_d   = 1'b0;
    overrun_d   = req_edge && (state_q != S_IDLE);
    convst_n_d  = convst_n_q;
    cs_n_d      = cs_n_q;
    sclk_d      = sclk_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_edge) begin
          state_d    = S_CONVST;
          busy_d     = 1'b1;
          convst_n_d = 1'b0;
          cnt_d      = '0;
        end
      end
      S_CONVST: begin
        if (cnt_q == CONVST_LAST) begin
          state_d    = S_CONV_WAIT;
          convst_n_d = 1'b1;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CONV_WAIT: begin
        if (busy_fall) begin
          state_d = S_READ;
          cs_n_d  = 1'b0;
          sclk_d  = 1'b0;
          div_d   = '0;
          bit_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
          busy_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_READ: begin
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          // SDO is captured on the same edge that raises SCLK.
          if (!sclk_q) begin
            shift_d = {shift_q[DATA_WIDTH-2:0], i_adc_sdo};
          end else if (bit_q == BIT_LAST) begin
            state_d    = S_DONE;
            cs_n_d     = 1'b1;
            rd_valid_d = 1'b1;
            data_d     = shift_q;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q     <= S_IDLE;
      convst_q    <= 1'b0;
      busy_sync_q <= '0;
      busy_prev_q <= 1'b0;
      cnt_q       <= '0;
      div_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      busy_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      timeout_q   <= 1'b0;
      overrun_q   <= 1'b0;
      convst_n_q  <= 1'b1;
      cs_n_q      <= 1'b1;
      sclk_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      convst_q    <= convst_d;
      busy_sync_q <= busy_sync_d;
      busy_prev_q <= busy_prev_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      rd_valid_q  <= rd_valid_d;
      timeout_q   <= timeout_d;
      overrun_q   <= overrun_d;
      convst_n_q  <= convst_n_d;
      cs_n_q      <= cs_n_d;
      sclk_q      <= sclk_d;
    end
  end

  assign o_busy         = busy_q;
  assign o_data         = data_q;
  assign o_rd_valid     = rd_valid_q;
  assign o_timeout      = timeout_q;
  assign o_overrun      = overrun_q;
  assign o_adc_convst_n = convst_n_q;
  assign o_adc_cs_n     = cs_n_q;
  assign o_adc_sclk     = sclk_q;

endmodule

// File: tb/tb_adc_serial_if.sv
// Bench for adc_serial_if: an ADC pin model driven cycle by cycle, a vector table
// of corner cases, then random conversions checked against a transaction model.
module tb_adc_serial_if;

  localparam int W    = 11;
  localparam int DIV  = 4;
  localparam int CLEN = 2;
  localparam int TO   = 1024;

  logic         i_clk = 1'b0;
  logic         i_nrst = 1'b0;
  logic         i_convst = 1'b0;
  logic         i_adc_busy = 1'b0;
  logic         i_adc_sdo = 1'b0;
  logic         o_busy, o_rd_valid, o_timeout, o_overrun;
  logic         o_adc_convst_n, o_adc_cs_n, o_adc_sclk;
  logic [W-1:0] o_data;

  adc_serial_if #(
    .DATA_WIDTH(W), .SCLK_DIV(DIV), .CONVST_LEN(CLEN), .CONV_TIMEOUT(TO)
  ) dut (
    .i_clk(i_clk), .i_nrst(i_nrst), .i_convst(i_convst),
    .o_busy(o_busy), .o_data(o_data), .o_rd_valid(o_rd_valid),
    .o_timeout(o_timeout), .o_overrun(o_overrun),
    .o_adc_convst_n(o_adc_convst_n), .i_adc_busy(i_adc_busy),
    .o_adc_cs_n(o_adc_cs_n), .o_adc_sclk(o_adc_sclk), .i_adc_sdo(i_adc_sdo)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          n_conv, n_valid, n_timeout, n_overrun, n_rises;
    int          cs_low, convst_low, to_lat;
    logic [31:0] data_at_valid;
    logic        busy_at_valid, cs_at_valid, busy_after_valid;
    logic        rst_cs_n, rst_sclk, rst_busy;
    logic        finished;
  } res_t;

  typedef struct {
    logic [W-1:0] word;
    int           busy_len;
    bit           stuck;
    int           hold;
    int           ovr_at;
    int           rst_at;
    bit           exp_valid;
    bit           exp_timeout;
    int           exp_overrun;
  } vec_t;

  // One request, with the ADC pins modelled from the sampled outputs each cycle.
  task automatic run_conv(input logic [W-1:0] word, input int busy_len, input bit stuck,
                          input int hold, input int ovr_at, input int rst_at, output res_t r);
    int adc_cnt   = -1;
    int cw_cycle  = -1;
    int rst_cycle = -1;
    bit ovr_done  = 1'b0;
    bit seen_busy = 1'b0;
    bit p_convst_n = 1'b1;
    bit p_sclk     = 1'b0;
    bit p_valid    = 1'b0;
    r = '{default: 0};
    r.to_lat = -1;
    @(negedge i_clk);
    i_convst = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge i_clk);
      if (p_valid) r.busy_after_valid = o_busy;
      if (o_rd_valid) begin
        r.n_valid++;
        r.data_at_valid = 32'(o_data);
        r.busy_at_valid = o_busy;
        r.cs_at_valid   = o_adc_cs_n;
      end
      p_valid = o_rd_valid;
      if (o_timeout) begin
        r.n_timeout++;
        if (cw_cycle >= 0) r.to_lat = cyc - cw_cycle;
      end
      if (o_overrun) r.n_overrun++;
      if (!o_adc_cs_n) r.cs_low++;
      if (!o_adc_convst_n) r.convst_low++;
      if (o_adc_sclk && !p_sclk) r.n_rises++;
      if (!o_adc_convst_n && p_convst_n) begin
        r.n_conv++;
        adc_cnt = 0;
      end
      if (o_adc_convst_n && !p_convst_n) cw_cycle = cyc;
      p_sclk     = o_adc_sclk;
      p_convst_n = o_adc_convst_n;
      if (o_busy) seen_busy = 1'b1;

      i_convst = (cyc + 1 < hold);
      if (ovr_at > 0 && !ovr_done && r.n_rises == ovr_at) begin
        i_convst = 1'b1;
        ovr_done = 1'b1;
      end
      if (adc_cnt >= 0) begin
        adc_cnt++;
        if (stuck) i_adc_busy = (adc_cnt >= 2);
        else if (adc_cnt >= 2 + busy_len) begin
          i_adc_busy = 1'b0;
          adc_cnt = -1;
        end else i_adc_busy = (adc_cnt >= 2);
      end
      i_adc_sdo = (r.n_rises < W) ? word[W-1-r.n_rises] : 1'b0;

      if (rst_at > 0 && rst_cycle < 0 && r.n_rises == rst_at) begin
        i_nrst = 1'b0;
        #1;
        r.rst_cs_n = o_adc_cs_n;
        r.rst_sclk = o_adc_sclk;
        r.rst_busy = o_busy;
        rst_cycle  = cyc;
        i_adc_busy = 1'b0;
        adc_cnt    = -1;
      end
      if (rst_cycle >= 0 && cyc == rst_cycle + 2) i_nrst = 1'b1;

      if (seen_busy && !o_busy && cyc + 1 >= hold && (rst_cycle < 0 || cyc > rst_cycle + 3)) begin
        r.finished = 1'b1;
        break;
      end
    end
    i_convst   = 1'b0;
    i_adc_busy = 1'b0;
    i_nrst     = 1'b1;
    repeat (4) @(negedge i_clk);
  endtask

  // Compares one run with what the ADC protocol dictates for that request.
  task automatic check_run(input string tag, input vec_t v, input res_t r, inout logic [W-1:0] last_data);
    check({tag, " finished"}, 32'(r.finished), 32'd1);
    check({tag, " conversions"}, r.n_conv, 1);
    check({tag, " rd_valid count"}, r.n_valid, v.exp_valid ? 1 : 0);
    check({tag, " timeout count"}, r.n_timeout, v.exp_timeout ? 1 : 0);
    check({tag, " overrun count"}, r.n_overrun, v.exp_overrun);
    if (v.exp_valid) begin
      last_data = v.word;
      check({tag, " data"}, r.data_at_valid, 32'(v.word));
      check({tag, " busy at valid"}, 32'(r.busy_at_valid), 32'd1);
      check({tag, " cs_n at valid"}, 32'(r.cs_at_valid), 32'd1);
      check({tag, " busy after valid"}, 32'(r.busy_after_valid), 32'd0);
      check({tag, " sclk periods"}, r.n_rises, W);
      check({tag, " cs_n low cycles"}, r.cs_low, 2 * DIV * W);
      check({tag, " convst low cycles"}, r.convst_low, CLEN);
    end
    if (v.exp_timeout) begin
      check({tag, " timeout latency"}, r.to_lat, TO);
      check({tag, " cs_n never low"}, r.cs_low, 0);
    end
    if (v.rst_at > 0) begin
      last_data = '0;
      check({tag, " reset cs_n"}, 32'(r.rst_cs_n), 32'd1);
      check({tag, " reset sclk"}, 32'(r.rst_sclk), 32'd0);
      check({tag, " reset busy"}, 32'(r.rst_busy), 32'd0);
    end
    check({tag, " data held"}, 32'(o_data), 32'(last_data));
    check({tag, " idle busy"}, 32'(o_busy), 32'd0);
  endtask

  vec_t         vecs[8];
  res_t         res;
  vec_t         rv;
  logic [W-1:0] model_data;

  initial begin
    model_data = '0;
    vecs[0] = '{11'h5A3, 20, 1'b0,   1, 0, 0, 1'b1, 1'b0, 0};
    vecs[1] = '{11'h000,  5, 1'b0,   1, 0, 0, 1'b1, 1'b0, 0};
    vecs[2] = '{11'h2AA, 20, 1'b1,   1, 0, 0, 1'b0, 1'b1, 0};
    vecs[3] = '{11'h3C5, 20, 1'b0,   1, 0, 0, 1'b1, 1'b0, 0};
    vecs[4] = '{11'h6B1, 10, 1'b0,   1, 3, 0, 1'b1, 1'b0, 1};
    vecs[5] = '{11'h1FF, 12, 1'b0,   1, 0, 6, 1'b0, 1'b0, 0};
    vecs[6] = '{11'h7FF, 20, 1'b0,   1, 0, 0, 1'b1, 1'b0, 0};
    vecs[7] = '{11'h155, 20, 1'b0, 300, 0, 0, 1'b1, 1'b0, 0};

    repeat (3) @(negedge i_clk);
    i_nrst = 1'b1;
    repeat (5) @(negedge i_clk);
    i_nrst = 1'b0;
    #1;
    check("rst busy", 32'(o_busy), 32'd0);
    check("rst data", 32'(o_data), 32'd0);
    check("rst rd_valid", 32'(o_rd_valid), 32'd0);
    check("rst timeout", 32'(o_timeout), 32'd0);
    check("rst overrun", 32'(o_overrun), 32'd0);
    check("rst convst_n", 32'(o_adc_convst_n), 32'd1);
    check("rst cs_n", 32'(o_adc_cs_n), 32'd1);
    check("rst sclk", 32'(o_adc_sclk), 32'd0);
    repeat (2) @(negedge i_clk);
    i_nrst = 1'b1;
    repeat (3) @(negedge i_clk);

    for (int i = 0; i < 8; i++) begin
      run_conv(vecs[i].word, vecs[i].busy_len, vecs[i].stuck, vecs[i].hold,
               vecs[i].ovr_at, vecs[i].rst_at, res);
      check_run($sformatf("vec%0d", i), vecs[i], res, model_data);
    end

    for (int i = 0; i < 20; i++) begin
      rv = '{W'($urandom), int'($urandom_range(1, 40)), 1'b0, 1, 0, 0, 1'b1, 1'b0, 0};
      run_conv(rv.word, rv.busy_len, rv.stuck, rv.hold, rv.ovr_at, rv.rst_at, res);
      check_run($sformatf("rnd%0d", i), rv, res, model_data);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
